// File: rtl/eviction_pkg.sv
// rtl/eviction_pkg.sv - shared widths and writeback state type for the eviction drain path
package eviction_pkg;
  localparam int ADDR_W   = 12;
  localparam int OFFSET_W = 4;
  localparam int DATA_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;
endpackage

// File: rtl/eviction_writeback_if.sv
// rtl/eviction_writeback_if.sv - eviction, lookup, arbiter and pmem signals of the writeback block
interface eviction_writeback_if;
  import eviction_pkg::*;

  logic                         evict_valid;
  logic                         evict_ready;
  logic [ADDR_W-1:0]            evict_address;
  logic [DATA_W-1:0]            evict_data;
  logic [ADDR_W-1:0]            lookup_address;
  logic                         lookup_hit;
  logic [DATA_W-1:0]            lookup_data;
  logic                         wb_req;
  logic                         wb_grant;
  logic                         pmem_write;
  logic [ADDR_W+OFFSET_W-1:0]   pmem_address;
  logic [DATA_W-1:0]            pmem_wdata;
  logic                         pmem_resp;

  modport slave (
    input  evict_valid, evict_address, evict_data, lookup_address, wb_grant, pmem_resp,
    output evict_ready, lookup_hit, lookup_data, wb_req, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output evict_valid, evict_address, evict_data, lookup_address, wb_grant, pmem_resp,
    input  evict_ready, lookup_hit, lookup_data, wb_req, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/wb_entry_reg.sv
// rtl/wb_entry_reg.sv - held eviction line (valid, address, data); load beats clear so a replacement survives
module wb_entry_reg
  import eviction_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_address <= i_address;
      r_data    <= i_data;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
      r_address <= '0;
      r_data    <= '0;
    end
  end

  assign o_valid   = r_valid;
  assign o_address = r_address;
  assign o_data    = r_data;
endmodule

// File: rtl/eviction_writeback.sv
// rtl/eviction_writeback.sv - holds one evicted line and writes it to pmem via the arbiter
// Optional forwarding of the held line to cache lookups: EVICT_FORWARD_EN
module eviction_writeback
  import eviction_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  eviction_writeback_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_HOLD  = HOLD;
  localparam logic [1:0] ST_WRITE = WRITE;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_evict_ready;
  logic              w_transfer;
  logic              w_done;
  logic              w_writing;
  logic              w_entry_valid;
  logic [ADDR_W-1:0] w_entry_address;
  logic [DATA_W-1:0] w_entry_data;

  assign w_writing     = (r_state == ST_WRITE);
  assign w_done        = w_writing & bus.pmem_resp;
  assign w_evict_ready = (r_state == ST_IDLE) | w_done;
  assign w_transfer    = bus.evict_valid & w_evict_ready;

  // A new line accepted on the completing cycle goes straight back to HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_transfer) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.wb_grant) w_state_nxt = ST_WRITE;
      ST_WRITE: if (bus.pmem_resp) w_state_nxt = w_transfer ? ST_HOLD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  wb_entry_reg u_entry (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_transfer),
    .i_clear   (w_done),
    .i_address (bus.evict_address),
    .i_data    (bus.evict_data),
    .o_valid   (w_entry_valid),
    .o_address (w_entry_address),
    .o_data    (w_entry_data)
  );

  assign bus.evict_ready  = w_evict_ready;
  assign bus.wb_req       = (r_state == ST_HOLD) | w_writing;
  assign bus.pmem_write   = w_writing;
  assign bus.pmem_address = w_writing ? {w_entry_address, {OFFSET_W{1'b0}}} : '0;
  assign bus.pmem_wdata   = w_writing ? w_entry_data : '0;

`ifdef EVICT_FORWARD_EN
  logic w_hit;
  assign w_hit           = w_entry_valid & (bus.lookup_address == w_entry_address);
  assign bus.lookup_hit  = w_hit;
  assign bus.lookup_data = w_hit ? w_entry_data : '0;
`else
  logic w_unused_lookup;
  assign w_unused_lookup = ^{bus.lookup_address, w_entry_valid};
  assign bus.lookup_hit  = 1'b0;
  assign bus.lookup_data = '0;
`endif
endmodule

// File: tb/tb_eviction_writeback.sv
// tb/tb_eviction_writeback.sv - scoreboard bench for eviction_writeback with directed and random traffic
module tb_eviction_writeback;
  import eviction_pkg::*;

`ifdef EVICT_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eviction_writeback_if bus ();

  eviction_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit                m_init    = 1'b0;
  bit                m_held    = 1'b0;
  bit                m_writing = 1'b0;
  bit                m_fresh   = 1'b0;
  logic [ADDR_W-1:0] m_addr    = '0;
  logic [DATA_W-1:0] m_data    = '0;
  line_t             sb_q[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a line is pending from acceptance until the memory acknowledges it
  task automatic step();
    bit acc;
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1; m_held = 1'b0; m_writing = 1'b0; m_fresh = 1'b1;
      sb_q.delete();
    end else if (m_init) begin
      acc = bus.evict_valid && (!m_held || (m_writing && bus.pmem_resp));
      if (m_writing && bus.pmem_resp) begin
        m_held = 1'b0; m_writing = 1'b0;
      end else if (m_held && !m_writing && bus.wb_grant) begin
        m_writing = 1'b1;
      end
      if (acc) begin
        m_held = 1'b1; m_writing = 1'b0; m_fresh = 1'b0;
        m_addr = bus.evict_address; m_data = bus.evict_data;
        sb_q.push_back('{a: bus.evict_address, d: bus.evict_data});
      end
    end
    #1;
  endtask

  initial begin
    line_t e;
    logic  exp_hit;
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("evict_ready", 128'(bus.evict_ready), 128'(!m_held || (m_writing && bus.pmem_resp)));
        chk("wb_req", 128'(bus.wb_req), 128'(m_held));
        chk("pmem_write", 128'(bus.pmem_write), 128'(m_writing));
        exp_hit = FWD && m_held && (bus.lookup_address == m_addr);
        chk("lookup_hit", 128'(bus.lookup_hit), 128'(exp_hit));
        chk("lookup_data", bus.lookup_data, exp_hit ? m_data : '0);
        if (m_writing) begin
          chk("pmem_address", 128'(bus.pmem_address), 128'({m_addr, 4'h0}));
          chk("pmem_wdata", bus.pmem_wdata, m_data);
        end else if (m_fresh) begin
          chk("pmem_address_rst", 128'(bus.pmem_address), '0);
          chk("pmem_wdata_rst", bus.pmem_wdata, '0);
        end
        if (m_writing && bus.pmem_resp) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_underflow: write completed with no expected line at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            chk("sb_address", 128'(bus.pmem_address), 128'({e.a, 4'h0}));
            chk("sb_wdata", bus.pmem_wdata, e.d);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.evict_valid = 1'b0; bus.wb_grant = 1'b0; bus.pmem_resp = 1'b0;
  endtask

  task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.evict_valid = 1'b1; bus.evict_address = a; bus.evict_data = d;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.evict_address = '0; bus.evict_data = '0; bus.lookup_address = '0;
    step(); step();
    rst = 1'b0;

    // Single eviction: grant two cycles after accept, resp on the third write cycle
    offer(12'h0A5, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98);
    step();
    bus.evict_valid = 1'b0; bus.lookup_address = 12'h0A5;
    step();
    bus.lookup_address = 12'h0A6; bus.wb_grant = 1'b1;
    step(); step(); step();
    bus.pmem_resp = 1'b1;
    step();
    idle_inputs(); bus.lookup_address = 12'h0A5;
    step();

    // Back-to-back: second line offered during the completing cycle
    offer(12'h111, {4{32'h1111_2222}});
    step();
    bus.evict_valid = 1'b0; bus.wb_grant = 1'b1;
    step(); step();
    bus.pmem_resp = 1'b1;
    offer(12'h1F0, {4{32'hA5A5_0F0F}});
    step();
    idle_inputs(); bus.lookup_address = 12'h1F0;
    step();
    bus.wb_grant = 1'b1;
    step();
    bus.pmem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    // Reset in the middle of a write, then a stray response
    offer(12'h2AA, {4{32'h0BAD_F00D}});
    step();
    bus.evict_valid = 1'b0; bus.wb_grant = 1'b1; bus.lookup_address = 12'h2AA;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; bus.wb_grant = 1'b0; bus.pmem_resp = 1'b1;
    step();
    idle_inputs();
    step();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.evict_valid   = ($urandom_range(0, 2) != 0);
      bus.evict_address = ($urandom_range(0, 3) == 0) ? m_addr : ADDR_W'($urandom);
      bus.evict_data    = {$urandom, $urandom, $urandom, $urandom};
      bus.lookup_address = $urandom_range(0, 1) ? m_addr : ADDR_W'($urandom);
      if (m_writing) begin
        bus.wb_grant  = 1'b1;
        bus.pmem_resp = ($urandom_range(0, 2) == 0);
      end else if (m_held) begin
        bus.wb_grant  = $urandom_range(0, 1) != 0;
        bus.pmem_resp = ($urandom_range(0, 7) == 0);
      end else begin
        bus.wb_grant  = ($urandom_range(0, 7) == 0);
        bus.pmem_resp = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    rst = 1'b0;
    bus.evict_valid = 1'b0;
    for (int i = 0; i < 100 && m_held; i++) begin
      bus.wb_grant  = 1'b1;
      bus.pmem_resp = m_writing;
      step();
    end
    idle_inputs();
    if (m_held) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: line still pending after 100 cycles");
    end
    step();
    @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
